acc_offload_tracker: RTL and testbench

ACC_OFFLOAD_TRACKER -- requirements
Module: acc_offload_tracker

---
 rtl/acc_offload_tracker.sv | 210 +++++++++++++++++++++
 tb/tb_acc_offload_tracker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_offload_tracker.sv
// rtl/acc_offload_tracker.sv - Offload tracker between core offload port, predecoders and accelerator.
module acc_offload_tracker #(
  parameter int DataWidth      = 32,
  parameter int NumPrd         = 8,
  parameter int NumRs          = 3,
  parameter int MaxOutstanding = 4,
  parameter int ReqDepth       = 2,
  localparam int IdWidth   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
  localparam int AddrWidth = (NumPrd > 1) ? $clog2(NumPrd) : 1,
  localparam int OutWidth  = $clog2(MaxOutstanding + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                x_q_valid_i,
  output logic                                x_q_ready_o,
  input  logic [31:0]                         x_instr_i,
  input  logic [NumRs-1:0][DataWidth-1:0]     x_rs_i,
  input  logic [NumRs-1:0]                    x_rs_valid_i,
  output logic                                x_k_accept_o,
  output logic                                x_k_writeback_o,
  output logic [31:0]                         prd_instr_o,
  input  logic [NumPrd-1:0]                   prd_accept_i,
  input  logic [NumPrd-1:0][NumRs-1:0]        prd_use_rs_i,
  input  logic [NumPrd-1:0]                   prd_writeback_i,
  output logic                                c_q_valid_o,
  input  logic                                c_q_ready_i,
  output logic [AddrWidth-1:0]                c_addr_o,
  output logic [31:0]                         c_op_o,
  output logic [NumRs-1:0][DataWidth-1:0]     c_arg_o,
  output logic [IdWidth-1:0]                  c_id_o,
  input  logic                                c_p_valid_i,
  output logic                                c_p_ready_o,
  input  logic [IdWidth-1:0]                  c_p_id_i,
  input  logic [DataWidth-1:0]                c_p_data_i,
  input  logic                                c_p_error_i,
  output logic                                x_p_valid_o,
  input  logic                                x_p_ready_i,
  output logic [4:0]                          x_p_rd_o,
  output logic [DataWidth-1:0]                x_p_data_o,
  output logic                                x_p_error_o,
  output logic [OutWidth-1:0]                 outstanding_o,
  output logic                                err_unknown_id_o
);
  localparam int PtrWidth = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int CntWidth = $clog2(ReqDepth + 1);
  localparam int EntryW   = AddrWidth + 32 + NumRs * DataWidth + IdWidth;

  logic [MaxOutstanding-1:0] slot_valid_q, slot_valid_d;
  logic [MaxOutstanding-1:0] slot_wb_q, slot_wb_d;
  logic [4:0]                slot_rd_q [MaxOutstanding];
  logic [4:0]                slot_rd_d [MaxOutstanding];

  logic [EntryW-1:0]   mem_q [ReqDepth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;

  logic                 x_p_valid_q, x_p_valid_d, x_p_err_q, x_p_err_d, err_q, err_d;
  logic [4:0]           x_p_rd_q, x_p_rd_d;
  logic [DataWidth-1:0] x_p_data_q, x_p_data_d;

  logic [AddrWidth-1:0]           sel_idx;
  logic                           sel_found, wb_sel, src_ready, hazard, free_found, fire;
  logic [IdWidth-1:0]             free_idx;
  logic [NumRs-1:0]               use_rs;
  logic [NumRs-1:0][DataWidth-1:0] args_gated;
  logic [4:0]                     req_rd, resp_rd;
  logic                           fifo_empty, fifo_full, push_store, pop_mem;
  logic                           c_p_hs, resp_hit, resp_wb;
  logic [EntryW-1:0]              entry_in, head;
  logic [OutWidth-1:0]            pop_cnt;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(ReqDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_idx    = '0;
    sel_found  = 1'b0;
    free_idx   = '0;
    free_found = 1'b0;
    hazard     = 1'b0;
    req_rd     = x_instr_i[11:7];
    for (int i = 0; i < NumPrd; i++) begin
      if (prd_accept_i[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = AddrWidth'(i);
      end
    end
    use_rs    = prd_use_rs_i[sel_idx];
    wb_sel    = sel_found & prd_writeback_i[sel_idx];
    src_ready = &(x_rs_valid_i | ~use_rs);
    for (int r = 0; r < NumRs; r++) begin
      args_gated[r] = use_rs[r] ? x_rs_i[r] : '0;
    end
    // Allocation and hazard both look at pre-edge slot state only.
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (!slot_valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdWidth'(i);
      end
      if (slot_valid_q[i] && slot_wb_q[i] && slot_rd_q[i] == req_rd) hazard = 1'b1;
    end
    hazard = hazard & wb_sel & (req_rd != 5'd0);
  end

  assign fifo_empty      = (count_q == '0);
  assign fifo_full       = (count_q == CntWidth'(ReqDepth));
  assign fire            = x_q_valid_i & sel_found & src_ready & ~hazard & free_found & ~fifo_full;
  assign x_k_accept_o    = sel_found;
  assign x_k_writeback_o = wb_sel;
  assign x_q_ready_o     = ~sel_found | fire;
  assign prd_instr_o     = x_instr_i;

  // Fall-through: an empty FIFO presents the incoming entry directly.
  assign entry_in    = {sel_idx, x_instr_i, args_gated, free_idx};
  assign head        = fifo_empty ? entry_in : mem_q[rd_ptr_q];
  assign c_q_valid_o = ~fifo_empty | fire;
  assign {c_addr_o, c_op_o, c_arg_o, c_id_o} = head;
  assign pop_mem     = ~fifo_empty & c_q_ready_i;
  assign push_store  = fire & ~(fifo_empty & c_q_ready_i);

  always_comb begin
    wr_ptr_d = push_store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_mem ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntWidth'(push_store) - CntWidth'(pop_mem);
  end

  assign c_p_ready_o = ~x_p_valid_q | x_p_ready_i;
  assign c_p_hs      = c_p_valid_i & c_p_ready_o;

  always_comb begin
    resp_hit     = 1'b0;
    resp_wb      = 1'b0;
    resp_rd      = '0;
    pop_cnt      = '0;
    slot_valid_d = slot_valid_q;
    slot_wb_d    = slot_wb_q;
    slot_rd_d    = slot_rd_q;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (c_p_id_i == IdWidth'(i) && slot_valid_q[i]) begin
        resp_hit = 1'b1;
        resp_wb  = slot_wb_q[i];
        resp_rd  = slot_rd_q[i];
      end
      pop_cnt = pop_cnt + OutWidth'(slot_valid_q[i]);
    end
    if (fire) begin
      slot_valid_d[free_idx] = 1'b1;
      slot_wb_d[free_idx]    = wb_sel;
      slot_rd_d[free_idx]    = req_rd;
    end
    if (c_p_hs && resp_hit) slot_valid_d[c_p_id_i] = 1'b0;

    err_d       = err_q | (c_p_hs & ~resp_hit);
    x_p_valid_d = x_p_valid_q;
    x_p_rd_d    = x_p_rd_q;
    x_p_data_d  = x_p_data_q;
    x_p_err_d   = x_p_err_q;
    if (c_p_hs && resp_hit && resp_wb) begin
      x_p_valid_d = 1'b1;
      x_p_rd_d    = resp_rd;
      x_p_data_d  = c_p_data_i;
      x_p_err_d   = c_p_error_i;
    end else if (x_p_valid_q && x_p_ready_i) begin
      x_p_valid_d = 1'b0;
      x_p_rd_d    = '0;
      x_p_data_d  = '0;
      x_p_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_valid_q <= '0;
      slot_wb_q    <= '0;
      for (int i = 0; i < MaxOutstanding; i++) slot_rd_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      x_p_valid_q  <= 1'b0;
      x_p_rd_q     <= '0;
      x_p_data_q   <= '0;
      x_p_err_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_wb_q    <= slot_wb_d;
      slot_rd_q    <= slot_rd_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      x_p_valid_q  <= x_p_valid_d;
      x_p_rd_q     <= x_p_rd_d;
      x_p_data_q   <= x_p_data_d;
      x_p_err_q    <= x_p_err_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_store) mem_q[wr_ptr_q] <= entry_in;
  end

  assign x_p_valid_o      = x_p_valid_q;
  assign x_p_rd_o         = x_p_rd_q;
  assign x_p_data_o       = x_p_data_q;
  assign x_p_error_o      = x_p_err_q;
  assign err_unknown_id_o = err_q;
  assign outstanding_o    = pop_cnt;
endmodule

// File: tb/tb_acc_offload_tracker.sv
// tb/tb_acc_offload_tracker.sv - Directed self-checking bench for acc_offload_tracker.
module tb_acc_offload_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             x_q_valid, x_q_ready, x_k_accept, x_k_wb;
  logic [31:0]      x_instr, prd_instr, c_op;
  logic [2:0][31:0] x_rs, c_arg;
  logic [2:0]       x_rs_valid, c_addr, outstanding;
  logic [7:0]       prd_accept, prd_wb;
  logic [7:0][2:0]  prd_use_rs;
  logic             c_q_valid, c_q_ready, c_p_valid, c_p_ready, c_p_error;
  logic [1:0]       c_id, c_p_id;
  logic [31:0]      c_p_data, x_p_data;
  logic             x_p_valid, x_p_ready, x_p_error, err_unknown;
  logic [4:0]       x_p_rd;

  int n_cmp = 0;
  int n_err = 0;

  acc_offload_tracker dut (
    .clk_i(clk), .rst_i(rst),
    .x_q_valid_i(x_q_valid), .x_q_ready_o(x_q_ready), .x_instr_i(x_instr),
    .x_rs_i(x_rs), .x_rs_valid_i(x_rs_valid),
    .x_k_accept_o(x_k_accept), .x_k_writeback_o(x_k_wb),
    .prd_instr_o(prd_instr), .prd_accept_i(prd_accept), .prd_use_rs_i(prd_use_rs),
    .prd_writeback_i(prd_wb),
    .c_q_valid_o(c_q_valid), .c_q_ready_i(c_q_ready), .c_addr_o(c_addr), .c_op_o(c_op),
    .c_arg_o(c_arg), .c_id_o(c_id),
    .c_p_valid_i(c_p_valid), .c_p_ready_o(c_p_ready), .c_p_id_i(c_p_id),
    .c_p_data_i(c_p_data), .c_p_error_i(c_p_error),
    .x_p_valid_o(x_p_valid), .x_p_ready_i(x_p_ready), .x_p_rd_o(x_p_rd),
    .x_p_data_o(x_p_data), .x_p_error_o(x_p_error),
    .outstanding_o(outstanding), .err_unknown_id_o(err_unknown)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int p, input logic [4:0] rd, input logic wb);
    prd_accept    = '0;
    prd_accept[p] = 1'b1;
    prd_wb        = '0;
    prd_wb[p]     = wb;
    x_instr       = {20'h12345, rd, 7'h2b};
    x_q_valid     = 1'b1;
  endtask

  task automatic idle();
    x_q_valid  = 1'b0;
    prd_accept = '0;
  endtask

  task automatic resp(input logic [1:0] id, input logic [31:0] d, input logic e);
    c_p_valid = 1'b1;
    c_p_id    = id;
    c_p_data  = d;
    c_p_error = e;
  endtask

  int ids[4] = '{2, 0, 3, 1};

  initial begin
    x_q_valid = 0; x_instr = '0; x_rs = '0; x_rs_valid = 3'b111;
    prd_accept = '0; prd_wb = '0; prd_use_rs = '1;
    c_q_ready = 1; c_p_valid = 0; c_p_id = '0; c_p_data = '0; c_p_error = 0; x_p_ready = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_xp_valid", x_p_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unknown, 0);
    chk("rst_cq_valid", c_q_valid, 0);
    chk("rst_xp_rd", x_p_rd, 0);
    chk("rst_cp_ready", c_p_ready, 1);
    rst = 0;
    tick();

    x_q_valid = 1; x_instr = 32'hCAFE0013; #1;
    chk("noacc_accept", x_k_accept, 0);
    chk("noacc_ready", x_q_ready, 1);
    chk("noacc_cq_valid", c_q_valid, 0);
    chk("prd_instr", prd_instr, 32'hCAFE0013);
    tick();
    chk("noacc_outstanding", outstanding, 0);

    req(5, 3, 1); prd_accept[7] = 1'b1; prd_use_rs[5] = 3'b101;
    x_rs = {32'h33, 32'h22, 32'h11}; x_rs_valid = 3'b011; #1;
    chk("src_notready", x_q_ready, 0);
    chk("src_notready_cq", c_q_valid, 0);
    chk("src_accept", x_k_accept, 1);
    x_rs_valid = 3'b101; #1;
    chk("p5_ready", x_q_ready, 1);
    chk("p5_wb", x_k_wb, 1);
    chk("p5_cq_valid", c_q_valid, 1);
    chk("p5_addr", c_addr, 5);
    chk("p5_id", c_id, 0);
    chk("p5_op", c_op, {20'h12345, 5'd3, 7'h2b});
    chk("p5_arg0", c_arg[0], 32'h11);
    chk("p5_arg1_gated", c_arg[1], 0);
    chk("p5_arg2", c_arg[2], 32'h33);
    tick(); idle(); #1;
    chk("p5_outstanding", outstanding, 1);
    chk("p5_cq_drained", c_q_valid, 0);
    prd_use_rs[5] = 3'b111; x_rs_valid = 3'b111;
    resp(0, 32'hDEAD0003, 0);
    tick(); c_p_valid = 0;
    chk("p5_xp_valid", x_p_valid, 1);
    chk("p5_xp_rd", x_p_rd, 3);
    chk("p5_xp_data", x_p_data, 32'hDEAD0003);
    chk("p5_freed", outstanding, 0);
    tick();
    chk("p5_xp_clear", x_p_valid, 0);

    req(0, 7, 1); tick(); #1;
    chk("haz_block", x_q_ready, 0);
    chk("haz_cq", c_q_valid, 0);
    resp(0, 32'h77, 0); #1;
    chk("haz_pre_edge", x_q_ready, 0);
    tick(); c_p_valid = 0; #1;
    chk("haz_release", x_q_ready, 1);
    chk("haz_id", c_id, 0);
    chk("haz_xp_rd", x_p_rd, 7);
    chk("haz_outstanding0", outstanding, 0);
    tick(); idle();
    chk("haz_outstanding1", outstanding, 1);
    resp(0, 32'h78, 0); tick(); c_p_valid = 0; tick();
    chk("haz_done", outstanding, 0);

    for (int k = 0; k < 4; k++) begin
      req(1, 5'(k + 1), 1);
      tick();
    end
    req(2, 9, 1); #1;
    chk("full_block", x_q_ready, 0);
    chk("full_outstanding", outstanding, 4);
    idle();
    for (int j = 0; j < 4; j++) begin
      resp(2'(ids[j]), 32'hD000_0000 + 32'(ids[j]), ids[j] == 3);
      tick();
      chk("ooo_valid", x_p_valid, 1);
      chk("ooo_rd", x_p_rd, 5'(ids[j] + 1));
      chk("ooo_data", x_p_data, 32'hD000_0000 + 32'(ids[j]));
      chk("ooo_err", x_p_error, ids[j] == 3);
    end
    c_p_valid = 0;
    chk("ooo_outstanding", outstanding, 0);
    tick();
    chk("ooo_xp_clear", x_p_valid, 0);

    c_q_ready = 0; req(3, 10, 0); #1;
    chk("fifo_ft_valid", c_q_valid, 1);
    tick(); req(3, 11, 0); tick(); req(3, 12, 0); #1;
    chk("fifo_full_block", x_q_ready, 0);
    chk("fifo_head_id0", c_id, 0);
    idle(); c_q_ready = 1; #1;
    chk("fifo_head_valid", c_q_valid, 1);
    tick();
    chk("fifo_head_id1", c_id, 1);
    tick();
    chk("fifo_empty", c_q_valid, 0);
    chk("fifo_outstanding", outstanding, 2);
    resp(0, 32'h1, 0); tick(); c_p_valid = 0;
    chk("nowb_no_xp", x_p_valid, 0);
    chk("nowb_freed", outstanding, 1);
    resp(1, 32'h2, 0); tick(); c_p_valid = 0;
    chk("nowb_freed2", outstanding, 0);

    resp(3, 32'h3, 0); #1;
    chk("unk_cp_ready", c_p_ready, 1);
    tick(); c_p_valid = 0;
    chk("unk_err", err_unknown, 1);
    chk("unk_no_xp", x_p_valid, 0);
    tick();
    chk("unk_sticky", err_unknown, 1);

    req(4, 5, 1); tick(); req(4, 6, 1); tick(); idle();
    chk("stall_outstanding2", outstanding, 2);
    x_p_ready = 0; resp(0, 32'hAAAA5555, 0);
    tick(); resp(1, 32'hBBBB0000, 1); #1;
    chk("stall_cp_ready", c_p_ready, 0);
    chk("stall_rd0", x_p_rd, 5);
    tick();
    chk("stall_valid", x_p_valid, 1);
    chk("stall_rd1", x_p_rd, 5);
    chk("stall_data", x_p_data, 32'hAAAA5555);
    chk("stall_outstanding1", outstanding, 1);
    rst = 1; #1;
    chk("rst2_xp_valid", x_p_valid, 0);
    chk("rst2_xp_rd", x_p_rd, 0);
    chk("rst2_xp_data", x_p_data, 0);
    chk("rst2_err", err_unknown, 0);
    chk("rst2_outstanding", outstanding, 0);
    chk("rst2_cq_valid", c_q_valid, 0);
    c_p_valid = 0;
    tick(); rst = 0; x_p_ready = 1; tick();
    resp(1, 32'h9, 0); tick(); c_p_valid = 0;
    chk("post_rst_unk", err_unknown, 1);
    chk("post_rst_no_xp", x_p_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
